dbf_fine_apod: RTL and testbench



---
 rtl/dbf_fine_apod.sv | 177 +++++++++++++++++
 tb/tb_dbf_fine_apod.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbf_fine_apod.sv
// Fine-delay interpolator and apodisation weighting for one DBF channel.
// Define DBF_APOD_EN to multiply by apo_din; otherwise a unity weight (shift) is applied.
module dbf_fine_apod #(
  parameter int INPUT_WD = 14,
  parameter int APO_WD   = 16,
  parameter int FRAC_WD  = 8,
  parameter int ADDR_WD  = 6,
  parameter int ZONE_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic                start,
  input  logic [INPUT_WD-1:0] fine_din,
  input  logic                fine_din_valid,
  input  logic [ADDR_WD-1:0]  lut_addr,
  input  logic                lut_we,
  input  logic [FRAC_WD-1:0]  lut_wdata,
  input  logic [APO_WD-1:0]   apo_din,
  output logic [31:0]         dbf_ch_dout,
  output logic                dbf_ch_dout_valid
);

  localparam int DIFF_WD = INPUT_WD + 1;
  localparam int PROD_WD = DIFF_WD + FRAC_WD + 1;
  localparam int CNT_WD  = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam logic [ADDR_WD-1:0]        PTR_MAX = '1;
  localparam logic [CNT_WD-1:0]         CNT_END = CNT_WD'(ZONE_LEN - 1);
  localparam logic signed [PROD_WD-1:0] ROUND   = PROD_WD'(2 ** (FRAC_WD - 1));

  logic [1:0]          state_reg, state_next;
  logic                start_d_reg;
  logic [ADDR_WD-1:0]  zone_ptr_reg, zone_ptr_next;
  logic [CNT_WD-1:0]   zone_cnt_reg, zone_cnt_next;
  logic [INPUT_WD-1:0] x_prev_reg, x_prev_next;
  logic                accept;
  logic                run_accept;

  logic [FRAC_WD-1:0]  lut_mem [2**ADDR_WD];
  logic [FRAC_WD-1:0]  frac_rd_reg;

  logic                       s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic signed [DIFF_WD-1:0]  s1_diff_reg;
  logic [FRAC_WD-1:0]         s1_frac_reg;
  logic [INPUT_WD-1:0]        s1_xprev_reg, s2_xprev_reg;
  logic signed [PROD_WD-1:0]  s2_prod_reg;
  logic signed [DIFF_WD-1:0]  s3_interp_reg;
  logic signed [31:0]         interp_ext;
  logic signed [31:0]         weighted;

  // A window closing (start low) takes priority over a sample in the same cycle.
  assign accept     = fine_din_valid && !tx_en && start &&
                      (state_reg == PRIME || state_reg == RUN);
  assign run_accept = accept && (state_reg == RUN);

  always_comb begin
    state_next    = state_reg;
    zone_ptr_next = zone_ptr_reg;
    zone_cnt_next = zone_cnt_reg;
    x_prev_next   = x_prev_reg;
    case (state_reg)
      IDLE: begin
        if (start && !start_d_reg && !tx_en) state_next = PRIME;
      end
      PRIME, RUN: begin
        if (!start) begin
          state_next    = IDLE;
          zone_ptr_next = '0;
          zone_cnt_next = '0;
          x_prev_next   = '0;
        end else if (accept) begin
          state_next  = RUN;
          x_prev_next = fine_din;
          if (state_reg == RUN) begin
            if (zone_cnt_reg == CNT_END) begin
              zone_cnt_next = '0;
              if (zone_ptr_reg != PTR_MAX) zone_ptr_next = zone_ptr_reg + ADDR_WD'(1);
            end else begin
              zone_cnt_next = zone_cnt_reg + CNT_WD'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // start_d resets high so a start held through reset is not seen as a new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      start_d_reg  <= 1'b1;
      zone_ptr_reg <= '0;
      zone_cnt_reg <= '0;
      x_prev_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      start_d_reg  <= start;
      zone_ptr_reg <= zone_ptr_next;
      zone_cnt_reg <= zone_cnt_next;
      x_prev_reg   <= x_prev_next;
    end
  end

  // Reading at the next pointer keeps frac_rd_reg aligned with zone_ptr_reg.
  always_ff @(posedge clk) begin
    if (lut_we && state_reg == IDLE) lut_mem[lut_addr] <= lut_wdata;
    frac_rd_reg <= lut_mem[zone_ptr_next];
  end

`ifdef DBF_APOD_EN
  logic [APO_WD-1:0] s1_apo_reg, s2_apo_reg, s3_apo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_apo_reg <= '0;
      s2_apo_reg <= '0;
      s3_apo_reg <= '0;
    end else begin
      s1_apo_reg <= apo_din;
      s2_apo_reg <= s1_apo_reg;
      s3_apo_reg <= s2_apo_reg;
    end
  end

  assign weighted = interp_ext *
                    $signed({{(32-APO_WD){s3_apo_reg[APO_WD-1]}}, s3_apo_reg});
`else
  logic unused_apo;
  assign unused_apo = ^apo_din;
  assign weighted   = interp_ext <<< (APO_WD - 1);
`endif

  assign interp_ext = $signed({{(32-DIFF_WD){s3_interp_reg[DIFF_WD-1]}}, s3_interp_reg});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg      <= 1'b0;
      s1_diff_reg       <= '0;
      s1_frac_reg       <= '0;
      s1_xprev_reg      <= '0;
      s2_valid_reg      <= 1'b0;
      s2_prod_reg       <= '0;
      s2_xprev_reg      <= '0;
      s3_valid_reg      <= 1'b0;
      s3_interp_reg     <= '0;
      dbf_ch_dout       <= '0;
      dbf_ch_dout_valid <= 1'b0;
    end else begin
      s1_valid_reg <= run_accept;
      s1_diff_reg  <= $signed({fine_din[INPUT_WD-1], fine_din}) -
                      $signed({x_prev_reg[INPUT_WD-1], x_prev_reg});
      s1_frac_reg  <= frac_rd_reg;
      s1_xprev_reg <= x_prev_reg;

      s2_valid_reg <= s1_valid_reg;
      s2_prod_reg  <= $signed({{(FRAC_WD+1){s1_diff_reg[DIFF_WD-1]}}, s1_diff_reg}) *
                      $signed({{DIFF_WD{1'b0}}, s1_frac_reg});
      s2_xprev_reg <= s1_xprev_reg;

      // Round half up, then arithmetic shift back to sample scale.
      s3_valid_reg  <= s2_valid_reg;
      s3_interp_reg <= DIFF_WD'($signed({{(PROD_WD-INPUT_WD){s2_xprev_reg[INPUT_WD-1]}},
                                          s2_xprev_reg}) +
                                ((s2_prod_reg + ROUND) >>> FRAC_WD));

      dbf_ch_dout_valid <= s3_valid_reg;
      dbf_ch_dout       <= s3_valid_reg ? weighted : 32'sd0;
    end
  end

endmodule

// File: tb/tb_dbf_fine_apod.sv
// Directed self-checking bench for dbf_fine_apod; expectations follow DBF_APOD_EN if defined.
module tb_dbf_fine_apod;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic        start;
  logic [13:0] fine_din;
  logic        fine_din_valid;
  logic [5:0]  lut_addr;
  logic        lut_we;
  logic [7:0]  lut_wdata;
  logic [15:0] apo_din;
  logic [31:0] dbf_ch_dout;
  logic        dbf_ch_dout_valid;

  int checks   = 0;
  int failures = 0;
  int outq[$];

  dbf_fine_apod dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tx_en             (tx_en),
    .start             (start),
    .fine_din          (fine_din),
    .fine_din_valid    (fine_din_valid),
    .lut_addr          (lut_addr),
    .lut_we            (lut_we),
    .lut_wdata         (lut_wdata),
    .apo_din           (apo_din),
    .dbf_ch_dout       (dbf_ch_dout),
    .dbf_ch_dout_valid (dbf_ch_dout_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dbf_ch_dout_valid) outq.push_back($signed(dbf_ch_dout));
  end

  function automatic int exp_out(int xp, int xc, int f, int apo);
    int p;
    int interp;
    p      = (xc - xp) * f;
    interp = xp + ((p + 128) >>> 8);
`ifdef DBF_APOD_EN
    return interp * apo;
`else
    return interp * 32768;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lut_write(input int addr, input int val);
    lut_addr  = 6'(addr);
    lut_wdata = 8'(val);
    lut_we    = 1'b1;
    tick(1);
    lut_we    = 1'b0;
  endtask

  task automatic begin_window();
    start = 1'b1;
    tick(1);
  endtask

  task automatic end_window();
    fine_din_valid = 1'b0;
    start          = 1'b0;
    tick(8);
  endtask

  task automatic push(input int x);
    fine_din       = 14'(x);
    fine_din_valid = 1'b1;
    tick(1);
    fine_din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_en = 1'b0; start = 1'b0; fine_din = '0; fine_din_valid = 1'b0;
    lut_addr = '0; lut_we = 1'b0; lut_wdata = '0; apo_din = '0;
    tick(3);
    checks++;
    if (dbf_ch_dout !== 32'd0 || dbf_ch_dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got dout=%0d valid=%0b expected 0/0", dbf_ch_dout, dbf_ch_dout_valid);
    end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (dbf_ch_dout !== 32'd0 || dbf_ch_dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got dout=%0d valid=%0b expected 0/0", dbf_ch_dout, dbf_ch_dout_valid);
    end
  endtask

  task automatic test_basic();
    int expv;
`ifdef DBF_APOD_EN
    expv = 2457600;
`else
    expv = 4915200;
`endif
    lut_write(0, 128);
    apo_din = 16'd16384;
    outq.delete();
    begin_window();
    push(100);
    fine_din = 14'd200;
    fine_din_valid = 1'b1;
    tick(1);
    fine_din_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i == 3) begin
        if (dbf_ch_dout_valid !== 1'b1 || $signed(dbf_ch_dout) !== expv) begin
          failures++;
          $display("FAIL basic_latency: got valid=%0b dout=%0d expected 1/%0d",
                   dbf_ch_dout_valid, $signed(dbf_ch_dout), expv);
        end
      end else if (dbf_ch_dout_valid !== 1'b0 || dbf_ch_dout !== 32'd0) begin
        failures++;
        $display("FAIL basic_idle_cycle%0d: got valid=%0b dout=%0d expected 0/0",
                 i, dbf_ch_dout_valid, $signed(dbf_ch_dout));
      end
      tick(1);
    end
    end_window();
    checks++;
    if (outq.size() != 1) begin
      failures++;
      $display("FAIL basic_count: got %0d outputs expected 1", outq.size());
    end
  endtask

  task automatic test_negative();
    int expv;
`ifdef DBF_APOD_EN
    expv = -1638350;
`else
    expv = -1638400;
`endif
    lut_write(0, 64);
    apo_din = 16'd32767;
    outq.delete();
    begin_window();
    push(-100);
    push(100);
    // start falls together with a valid sample: it must not be accepted
    fine_din = 14'd1000;
    fine_din_valid = 1'b1;
    start = 1'b0;
    tick(1);
    end_window();
    checks++;
    if (outq.size() != 1) begin
      failures++;
      $display("FAIL neg_count: got %0d outputs expected 1", outq.size());
    end else begin
      checks++;
      if (outq[0] != expv) begin
        failures++;
        $display("FAIL neg_value: got %0d expected %0d", outq[0], expv);
      end
    end
  endtask

  task automatic test_zone();
    lut_write(0, 0);
    lut_write(1, 255);
    apo_din = 16'd1000;
    outq.delete();
    begin_window();
    push(0);
    for (int k = 1; k <= 17; k++) push(k * 256);
    end_window();
    checks++;
    if (outq.size() != 17) begin
      failures++;
      $display("FAIL zone_count: got %0d outputs expected 17", outq.size());
    end else begin
      for (int k = 1; k <= 17; k++) begin
        int expv;
        expv = exp_out((k - 1) * 256, k * 256, (k <= 16) ? 0 : 255, 1000);
        checks++;
        if (outq[k-1] != expv) begin
          failures++;
          $display("FAIL zone_out%0d: got %0d expected %0d", k, outq[k-1], expv);
        end
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 64; i++) lut_write(i, i * 4);
    apo_din = 16'd3;
    outq.delete();
    begin_window();
    push(0);
    for (int k = 1; k <= 1034; k++) begin
      if (k == 500) begin
        lut_addr = 6'd0; lut_wdata = 8'd200; lut_we = 1'b1;
      end
      push((k % 2) ? 256 : 0);
      lut_we = 1'b0;
    end
    end_window();
    checks++;
    if (outq.size() != 1034) begin
      failures++;
      $display("FAIL sat_count: got %0d outputs expected 1034", outq.size());
    end else begin
      for (int k = 1; k <= 1034; k++) begin
        int ptr;
        int expv;
        ptr  = (k - 1) / 16;
        if (ptr > 63) ptr = 63;
        expv = exp_out(((k - 1) % 2) ? 256 : 0, (k % 2) ? 256 : 0, ptr * 4, 3);
        checks++;
        if (outq[k-1] != expv) begin
          failures++;
          $display("FAIL sat_out%0d: got %0d expected %0d", k, outq[k-1], expv);
        end
      end
    end
    // LUT[0] must still hold 0 despite the write attempted while running
    outq.delete();
    begin_window();
    push(100);
    push(200);
    end_window();
    checks++;
    if (outq.size() != 1 || outq[0] != exp_out(100, 200, 0, 3)) begin
      failures++;
      $display("FAIL lut_write_in_run: got %0d outputs first=%0d expected 1/%0d",
               outq.size(), (outq.size() > 0) ? outq[0] : 0, exp_out(100, 200, 0, 3));
    end
  endtask

  task automatic test_tx_gap();
    lut_write(0, 128);
    apo_din = 16'd16384;
    outq.delete();
    begin_window();
    push(100);
    push(200);
    tx_en = 1'b1;
    for (int i = 0; i < 5; i++) push(5000 + i);
    tx_en = 1'b0;
    push(300);
    end_window();
    checks++;
    if (outq.size() != 2) begin
      failures++;
      $display("FAIL tx_count: got %0d outputs expected 2", outq.size());
    end else begin
      checks++;
      if (outq[0] != exp_out(100, 200, 128, 16384)) begin
        failures++;
        $display("FAIL tx_before: got %0d expected %0d", outq[0], exp_out(100, 200, 128, 16384));
      end
      checks++;
      if (outq[1] != exp_out(200, 300, 128, 16384)) begin
        failures++;
        $display("FAIL tx_after: got %0d expected %0d", outq[1], exp_out(200, 300, 128, 16384));
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    apo_din = 16'd16384;
    begin_window();
    push(100);
    push(200);
    push(300);
    push(400);
    push(500);
    checks++;
    if (dbf_ch_dout_valid !== 1'b1 || $signed(dbf_ch_dout) !== exp_out(100, 200, 128, 16384)) begin
      failures++;
      $display("FAIL b2b_before_reset: got valid=%0b dout=%0d expected 1/%0d",
               dbf_ch_dout_valid, $signed(dbf_ch_dout), exp_out(100, 200, 128, 16384));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dbf_ch_dout_valid !== 1'b0 || dbf_ch_dout !== 32'd0) begin
      failures++;
      $display("FAIL reset_midflight: got valid=%0b dout=%0d expected 0/0",
               dbf_ch_dout_valid, $signed(dbf_ch_dout));
    end
    tick(2);
    outq.delete();
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) push(600 + i * 100);
    tick(8);
    checks++;
    if (outq.size() != 0) begin
      failures++;
      $display("FAIL reset_no_output: got %0d outputs expected 0", outq.size());
    end
    end_window();
    begin_window();
    push(100);
    push(200);
    end_window();
    checks++;
    if (outq.size() != 1 || outq[0] != exp_out(100, 200, 128, 16384)) begin
      failures++;
      $display("FAIL reset_restart: got %0d outputs first=%0d expected 1/%0d",
               outq.size(), (outq.size() > 0) ? outq[0] : 0, exp_out(100, 200, 128, 16384));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_zone();
    test_saturate();
    test_tx_gap();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
